// File: rtl/mini_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mini_cpu_pkg : opcode/state types and instruction-field positions
// Revision     : 1.0
// ============================================================================
package mini_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_MOVI = 4'd1,
    OP_MOV  = 4'd2,
    OP_ADD  = 4'd3,
    OP_IN   = 4'd4,
    OP_OUT  = 4'd5,
    OP_OUTI = 4'd6,
    OP_JMP  = 4'd7,
    OP_JNC  = 4'd8,
    OP_HALT = 4'd9,
    OP_JZ   = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  // Instruction word layout, MSB first: op[3:0] | rd | rs | imm
  function automatic int imm_lsb();
    return 0;
  endfunction

  function automatic int rs_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rd_lsb(input int rsel_w, input int data_w);
    return rsel_w + data_w;
  endfunction

  function automatic int op_lsb(input int rsel_w, input int data_w);
    return 2 * rsel_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mini_cpu_alu.sv
`default_nettype none
// ============================================================================
// mini_cpu_alu : combinational (DATA_W+1)-bit adder shared by ADDI and ADD
// Revision     : 1.0
// ============================================================================
module mini_cpu_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum   = w_sum[DATA_W-1:0];
  assign o_carry = w_sum[DATA_W];

endmodule
`default_nettype wire

// File: rtl/mini_cpu_core.sv
`default_nettype none
// ============================================================================
// mini_cpu_core : parametrised FETCH/EXEC/HALT CPU with external sync ROM
//                 optional zero flag and JZ opcode under MINI_CPU_ZFLAG_EN
// Revision      : 1.0
// ============================================================================
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      ce,
  output logic [ADDR_W-1:0]                         pm_addr,
  input  logic [4+2*$clog2(NUM_REGS)+DATA_W-1:0]    pm_data,
  input  logic [DATA_W-1:0]                         in_port,
  output logic [DATA_W-1:0]                         out_port,
  output logic                                      carry,
`ifdef MINI_CPU_ZFLAG_EN
  output logic                                      zero,
`endif
  output logic                                      halted,
  output logic                                      illegal,
  output logic [3:0]                                dbg_op,
  output logic [NUM_REGS*DATA_W-1:0]                dbg_regs
);

  localparam int RSEL_W    = $clog2(NUM_REGS);
  localparam int INSTR_W   = 4 + 2 * RSEL_W + DATA_W;
  localparam int c_op_lsb  = op_lsb(RSEL_W, DATA_W);
  localparam int c_rd_lsb  = rd_lsb(RSEL_W, DATA_W);
  localparam int c_rs_lsb  = rs_lsb(DATA_W);
  localparam int c_imm_lsb = imm_lsb();

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [INSTR_W-1:0]  w_ir_nxt;
  logic                r_carry;
  logic                w_carry_nxt;
  logic [DATA_W-1:0]   r_out;
  logic [DATA_W-1:0]   w_out_nxt;
  logic                r_illegal;
  logic                w_illegal_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                w_reg_we;
  logic [DATA_W-1:0]   w_reg_wdata;
`ifdef MINI_CPU_ZFLAG_EN
  logic                r_zero;
  logic                w_zero_nxt;
`endif

  opcode_e             w_op;
  logic [RSEL_W-1:0]   w_rd;
  logic [RSEL_W-1:0]   w_rs;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_target;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W-1:0]   w_alu_b;
  logic [DATA_W-1:0]   w_alu_sum;
  logic                w_alu_carry;

  assign w_op     = opcode_e'(r_ir[c_op_lsb +: 4]);
  assign w_rd     = r_ir[c_rd_lsb +: RSEL_W];
  assign w_rs     = r_ir[c_rs_lsb +: RSEL_W];
  assign w_imm    = r_ir[c_imm_lsb +: DATA_W];
  assign w_target = w_imm[ADDR_W-1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_alu_b  = (w_op == OP_ADD) ? w_rs_val : w_imm;

  mini_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a     (w_rd_val),
    .i_b     (w_alu_b),
    .o_sum   (w_alu_sum),
    .o_carry (w_alu_carry)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_carry_nxt   = r_carry;
    w_out_nxt     = r_out;
    w_illegal_nxt = r_illegal;
    w_reg_we      = 1'b0;
    w_reg_wdata   = '0;
`ifdef MINI_CPU_ZFLAG_EN
    w_zero_nxt    = r_zero;
`endif
    case (r_state)
      FETCH: begin
        w_ir_nxt    = pm_data;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = r_pc + ADDR_W'(1);
        // JNC below reads r_carry, i.e. the flag before this clear
        w_carry_nxt = 1'b0;
        case (w_op)
          OP_ADDI, OP_ADD: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_alu_sum;
            w_carry_nxt = w_alu_carry;
          end
          OP_MOVI: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_imm;
          end
          OP_MOV: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = w_rs_val;
          end
          OP_IN: begin
            w_reg_we    = 1'b1;
            w_reg_wdata = in_port;
          end
          OP_OUT:  w_out_nxt = w_rs_val;
          OP_OUTI: w_out_nxt = w_imm;
          OP_JMP:  w_pc_nxt  = w_target;
          OP_JNC: begin
            if (!r_carry) w_pc_nxt = w_target;
          end
          OP_HALT: begin
            w_state_nxt = HALT;
            w_pc_nxt    = r_pc;
          end
`ifdef MINI_CPU_ZFLAG_EN
          OP_JZ: begin
            if (r_zero) w_pc_nxt = w_target;
          end
`endif
          default: w_illegal_nxt = 1'b1;
        endcase
`ifdef MINI_CPU_ZFLAG_EN
        // Only the result-producing opcodes write a register
        w_zero_nxt = w_reg_we && (w_reg_wdata == '0);
`endif
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_carry   <= 1'b0;
      r_out     <= '0;
      r_illegal <= 1'b0;
`ifdef MINI_CPU_ZFLAG_EN
      r_zero    <= 1'b0;
`endif
    end else if (ce) begin
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_carry   <= w_carry_nxt;
      r_out     <= w_out_nxt;
      r_illegal <= w_illegal_nxt;
`ifdef MINI_CPU_ZFLAG_EN
      r_zero    <= w_zero_nxt;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (ce && w_reg_we) begin
      r_regs[w_rd] <= w_reg_wdata;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg_regs
    assign dbg_regs[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign pm_addr  = r_pc;
  assign out_port = r_out;
  assign carry    = r_carry;
  assign halted   = (r_state == HALT);
  assign illegal  = r_illegal;
  assign dbg_op   = r_ir[c_op_lsb +: 4];
`ifdef MINI_CPU_ZFLAG_EN
  assign zero     = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mini_cpu_core.sv
`default_nettype none
// ============================================================================
// tb_mini_cpu_core : directed-program bench for mini_cpu_core (default params)
// Revision         : 1.0
// ============================================================================
module tb_mini_cpu_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ce  = 1'b0;
  logic [3:0]  pm_addr;
  logic [11:0] pm_data = '0;
  logic [3:0]  in_port = '0;
  logic [3:0]  out_port;
  logic        carry;
  logic        halted;
  logic        illegal;
  logic [3:0]  dbg_op;
  logic [15:0] dbg_regs;
`ifdef MINI_CPU_ZFLAG_EN
  logic        zero;
`endif

  logic [11:0] rom [16];
  int          n_vec = 0;
  int          n_err = 0;

  mini_cpu_core dut (
    .CLK      (CLK),
    .RST      (RST),
    .ce       (ce),
    .pm_addr  (pm_addr),
    .pm_data  (pm_data),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry),
`ifdef MINI_CPU_ZFLAG_EN
    .zero     (zero),
`endif
    .halted   (halted),
    .illegal  (illegal),
    .dbg_op   (dbg_op),
    .dbg_regs (dbg_regs)
  );

  always #5 CLK = ~CLK;

  // Synchronous program ROM
  always @(posedge CLK) pm_data <= rom[pm_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [3:0] rv(input int i);
    return dbg_regs[i*4 +: 4];
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    ce  = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ce  = 1'b0;
  endtask

  // One ce tick, followed by a ce-low edge so the ROM can follow pm_addr
  task automatic tick();
    @(negedge CLK);
    ce = 1'b1;
    @(negedge CLK);
    ce = 1'b0;
  endtask

  task automatic instr();
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    clear_rom();
    do_reset();
    chk("rst_pc", pm_addr, 4'h0);
    chk("rst_regs", dbg_regs, 16'h0);
    chk("rst_out", out_port, 4'h0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_op", dbg_op, 4'h0);

    // ADDI carry-out, JNC not taken, carry cleared
    clear_rom();
    rom[0] = ins(4'd1, 2'd0, 2'd0, 4'd7);
    rom[1] = ins(4'd0, 2'd0, 2'd0, 4'd9);
    rom[2] = ins(4'd8, 2'd0, 2'd0, 4'd0);
    rom[3] = ins(4'd5, 2'd0, 2'd0, 4'd0);
    rom[4] = ins(4'd9, 2'd0, 2'd0, 4'd0);
    do_reset();
    instr();
    chk("movi_r0", rv(0), 4'd7);
    instr();
    chk("addi_r0", rv(0), 4'd0);
    chk("addi_carry", carry, 1'b1);
    instr();
    chk("jnc_nt_pc", pm_addr, 4'd3);
    chk("jnc_clr_c", carry, 1'b0);
    instr();
    chk("out_r0", out_port, 4'd0);
    chk("out_pc", pm_addr, 4'd4);

    // ADD rd==rs doubles, HALT freezes PC
    clear_rom();
    rom[0] = ins(4'd1, 2'd1, 2'd0, 4'd3);
    rom[1] = ins(4'd3, 2'd1, 2'd1, 4'd0);
    rom[2] = ins(4'd5, 2'd0, 2'd1, 4'd0);
    rom[3] = ins(4'd9, 2'd0, 2'd0, 4'd0);
    do_reset();
    repeat (3) instr();
    chk("add_r1", rv(1), 4'd6);
    chk("add_carry", carry, 1'b0);
    chk("out_r1", out_port, 4'd6);
    instr();
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pm_addr, 4'd3);
    repeat (20) tick();
    chk("halt_pc_20", pm_addr, 4'd3);
    chk("halt_flag_20", halted, 1'b1);
    chk("halt_out_20", out_port, 4'd6);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_halt_flag", halted, 1'b0);
    chk("rst_halt_pc", pm_addr, 4'd0);
    chk("rst_halt_regs", dbg_regs, 16'h0);

    // IN sampled at EXEC, OUTI, JMP back to 0
    clear_rom();
    rom[0] = ins(4'd4, 2'd2, 2'd0, 4'd0);
    rom[1] = ins(4'd6, 2'd0, 2'd0, 4'd5);
    rom[2] = ins(4'd7, 2'd0, 2'd0, 4'd0);
    do_reset();
    in_port = 4'hA;
    tick();
    chk("fetch_pc_hold", pm_addr, 4'd0);
    chk("fetch_op", dbg_op, 4'd4);
    chk("fetch_r2_hold", rv(2), 4'd0);
    tick();
    chk("in_r2", rv(2), 4'hA);
    chk("in_pc", pm_addr, 4'd1);
    instr();
    chk("outi", out_port, 4'd5);
    instr();
    chk("jmp_pc", pm_addr, 4'd0);
    in_port = 4'h0;

    // PC wrap and ce-low hold mid-EXEC
    clear_rom();
    rom[0]  = ins(4'd7, 2'd0, 2'd0, 4'd15);
    rom[15] = ins(4'd1, 2'd0, 2'd0, 4'd1);
    do_reset();
    instr();
    chk("jmp15_pc", pm_addr, 4'd15);
    tick();
    in_port = 4'h3;
    repeat (10) @(negedge CLK);
    chk("hold_pc", pm_addr, 4'd15);
    chk("hold_r0", rv(0), 4'd0);
    chk("hold_op", dbg_op, 4'd1);
    tick();
    chk("wrap_r0", rv(0), 4'd1);
    chk("wrap_pc", pm_addr, 4'd0);

    // JNC taken when carry clear
    clear_rom();
    rom[0] = ins(4'd1, 2'd0, 2'd0, 4'd1);
    rom[1] = ins(4'd0, 2'd0, 2'd0, 4'd2);
    rom[2] = ins(4'd8, 2'd0, 2'd0, 4'd6);
    rom[6] = ins(4'd5, 2'd0, 2'd0, 4'd0);
    do_reset();
    repeat (3) instr();
    chk("jnc_t_pc", pm_addr, 4'd6);
    instr();
    chk("jnc_t_out", out_port, 4'd3);

    // Illegal opcode: NOP, sticky flag, MOV afterwards
    clear_rom();
    rom[0] = ins(4'd1, 2'd3, 2'd0, 4'd9);
    rom[1] = ins(4'd12, 2'd3, 2'd0, 4'd5);
    rom[2] = ins(4'd1, 2'd0, 2'd0, 4'd2);
    rom[3] = ins(4'd2, 2'd1, 2'd0, 4'd0);
    rom[4] = ins(4'd9, 2'd0, 2'd0, 4'd0);
    do_reset();
    instr();
    chk("pre_ill_flag", illegal, 1'b0);
    instr();
    chk("ill_flag", illegal, 1'b1);
    chk("ill_r3", rv(3), 4'd9);
    chk("ill_pc", pm_addr, 4'd2);
    instr();
    instr();
    chk("ill_sticky", illegal, 1'b1);
    chk("mov_r1", rv(1), 4'd2);

`ifdef MINI_CPU_ZFLAG_EN
    clear_rom();
    rom[0] = ins(4'd1, 2'd0, 2'd0, 4'd0);
    rom[1] = ins(4'd10, 2'd0, 2'd0, 4'd8);
    do_reset();
    chk("z_rst", zero, 1'b0);
    instr();
    chk("z_movi", zero, 1'b1);
    instr();
    chk("jz_pc", pm_addr, 4'd8);
    chk("jz_legal", illegal, 1'b0);
    chk("jz_clr_z", zero, 1'b0);
`else
    clear_rom();
    rom[0] = ins(4'd10, 2'd0, 2'd0, 4'd8);
    do_reset();
    instr();
    chk("op10_illegal", illegal, 1'b1);
    chk("op10_pc", pm_addr, 4'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
